// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer:
// FSM state encoding and the default settle length.
package sw_debounce_pkg;

   typedef logic state_t;

   localparam state_t ST_STABLE   = 1'b0;
   localparam state_t ST_SETTLING = 1'b1;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/sw_sync.sv
// NSYNC-deep flop chain that brings a raw asynchronous
// level into the i_clk domain; clears to 0 on reset.
module sw_sync #(
   parameter int NSYNC = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic [NSYNC-1:0] sync_q;
   logic [NSYNC-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[NSYNC-2:0], i_d};
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign o_q = sync_q[NSYNC-1];

endmodule

// File: rtl/sw_debounce.sv
// Switch debouncer: synchronizer, settle timer FSM,
// registered edge pulses and accepted-transition counter.
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int NSYNC           = 2,
   parameter int TIME_BITS       = 16,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int NCOUNT          = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_sw,
   output logic              o_debounced,
   output logic              o_rise,
   output logic              o_fall,
   output logic              o_busy,
   output logic [NCOUNT-1:0] o_count
);

   localparam logic [TIME_BITS-1:0] TIMER_LOAD =
      TIME_BITS'(DEBOUNCE_CYCLES - 1);

   logic s_sw;

   state_t                state_q, state_d;
   logic [TIME_BITS-1:0]  timer_q, timer_d;
   logic                  deb_q, deb_d;
   logic                  rise_q, rise_d;
   logic                  fall_q, fall_d;
   logic                  busy_q, busy_d;
   logic [NCOUNT-1:0]     count_q, count_d;

   sw_sync #(
      .NSYNC (NSYNC)
   ) u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_sw),
      .o_q     (s_sw)
   );

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      deb_d   = deb_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      count_d = count_q;
      if (state_q == ST_STABLE) begin
         if (s_sw != deb_q) begin
            state_d = ST_SETTLING;
            timer_d = TIMER_LOAD;
         end
      end else begin
         // A re-match to the held level is a glitch: drop the candidate.
         if (s_sw == deb_q) begin
            state_d = ST_STABLE;
         end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
         end else begin
            state_d = ST_STABLE;
            deb_d   = s_sw;
            rise_d  = s_sw;
            fall_d  = ~s_sw;
            count_d = count_q + 1'b1;
         end
      end
      busy_d = (state_d == ST_SETTLING);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_STABLE;
         timer_q <= '0;
         deb_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         deb_q   <= deb_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign o_debounced = deb_q;
   assign o_rise      = rise_q;
   assign o_fall      = fall_q;
   assign o_busy      = busy_q;
   assign o_count     = count_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: per-cycle vector table
// plus a hand sequence for the single-cycle settle case.
module tb_sw_debounce;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, sw;
   logic       deb, rise, fall, busy;
   logic [1:0] cnt;

   logic       r1, sw1;
   logic       d1_deb, d1_rise, d1_fall, d1_busy;
   logic [7:0] d1_cnt;

   int vectors = 0;
   int miscompares = 0;

   sw_debounce #(
      .NSYNC           (2),
      .TIME_BITS       (16),
      .DEBOUNCE_CYCLES (4),
      .NCOUNT          (2)
   ) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_sw        (sw),
      .o_debounced (deb),
      .o_rise      (rise),
      .o_fall      (fall),
      .o_busy      (busy),
      .o_count     (cnt)
   );

   sw_debounce #(
      .NSYNC           (3),
      .TIME_BITS       (4),
      .DEBOUNCE_CYCLES (1),
      .NCOUNT          (8)
   ) dut1 (
      .i_clk       (clk),
      .i_reset     (r1),
      .i_sw        (sw1),
      .o_debounced (d1_deb),
      .o_rise      (d1_rise),
      .o_fall      (d1_fall),
      .o_busy      (d1_busy),
      .o_count     (d1_cnt)
   );

   typedef struct {
      logic       rst;
      logic       sw;
      logic       deb;
      logic       rise;
      logic       fall;
      logic       busy;
      logic [1:0] cnt;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic r, input logic s,
                      input logic d, input logic ri,
                      input logic fa, input logic bu,
                      input logic [1:0] c);
      vec_t v;
      v.rst = r; v.sw = s; v.deb = d; v.rise = ri;
      v.fall = fa; v.busy = bu; v.cnt = c;
      tv.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name,
                        input logic [31:0] got,
                        input logic [31:0] req);
      vectors++;
      if (got !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, got, req);
      end
   endtask

   initial begin
      int n;
      int busy_cnt;
      bit found;

      // Held-high switch across reset release: rises at edge 6.
      add(1,1, 0,0,0,0,0);
      add(1,1, 0,0,0,0,0);
      add(0,1, 0,0,0,0,0);
      add(0,1, 0,0,0,0,0);
      for (int k = 0; k < 4; k++) add(0,1, 0,0,0,1,0);
      add(0,1, 1,1,0,0,1);
      add(0,1, 1,0,0,0,1);
      add(0,1, 1,0,0,0,1);
      // Clean fall.
      add(0,0, 1,0,0,0,1);
      add(0,0, 1,0,0,0,1);
      for (int k = 0; k < 4; k++) add(0,0, 1,0,0,1,1);
      add(0,0, 0,0,1,0,2);
      add(0,0, 0,0,0,0,2);
      // Three-cycle glitch high: busy 3 cycles, no change.
      add(0,1, 0,0,0,0,2);
      add(0,1, 0,0,0,0,2);
      add(0,1, 0,0,0,1,2);
      add(0,0, 0,0,0,1,2);
      add(0,0, 0,0,0,1,2);
      add(0,0, 0,0,0,0,2);
      add(0,0, 0,0,0,0,2);
      // Bounce 1,0,1,0 then held 1.
      add(0,1, 0,0,0,0,2);
      add(0,0, 0,0,0,0,2);
      add(0,1, 0,0,0,1,2);
      add(0,0, 0,0,0,0,2);
      add(0,1, 0,0,0,1,2);
      add(0,1, 0,0,0,0,2);
      for (int k = 0; k < 4; k++) add(0,1, 0,0,0,1,2);
      add(0,1, 1,1,0,0,3);
      add(0,1, 1,0,0,0,3);
      // Fall wraps the 2-bit counter to 0.
      add(0,0, 1,0,0,0,3);
      add(0,0, 1,0,0,0,3);
      for (int k = 0; k < 4; k++) add(0,0, 1,0,0,1,3);
      add(0,0, 0,0,1,0,0);
      add(0,0, 0,0,0,0,0);
      // Rise again, then reset in the middle of a fall settle.
      add(0,1, 0,0,0,0,0);
      add(0,1, 0,0,0,0,0);
      for (int k = 0; k < 4; k++) add(0,1, 0,0,0,1,0);
      add(0,1, 1,1,0,0,1);
      add(0,1, 1,0,0,0,1);
      add(0,0, 1,0,0,0,1);
      add(0,0, 1,0,0,0,1);
      add(0,0, 1,0,0,1,1);
      add(1,0, 0,0,0,0,0);
      add(0,0, 0,0,0,0,0);
      add(0,0, 0,0,0,0,0);

      r1 = 1'b1;
      sw1 = 1'b0;
      rst = 1'b1;
      sw = 1'b1;

      for (int i = 0; i < tv.size(); i++) begin
         rst = tv[i].rst;
         sw = tv[i].sw;
         step();
         check($sformatf("vec%0d deb/rise/fall/busy/cnt", i),
               {26'd0, deb, rise, fall, busy, cnt},
               {26'd0, tv[i].deb, tv[i].rise, tv[i].fall,
                tv[i].busy, tv[i].cnt});
      end

      // DEBOUNCE_CYCLES=1, NSYNC=3: rise at edge 4, one busy cycle.
      check("d1_reset_state",
            {22'd0, d1_deb, d1_rise, d1_fall, d1_busy, d1_cnt},
            32'd0);
      r1 = 1'b0;
      sw1 = 1'b1;
      n = -1;
      busy_cnt = 0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (d1_busy) busy_cnt++;
         if (d1_deb) begin
            found = 1'b1;
            n = k;
         end
      end
      check("d1_rise_edge", n, 4);
      check("d1_busy_cycles", busy_cnt, 1);
      check("d1_rise_pulse", {31'd0, d1_rise}, 1);
      check("d1_count", {24'd0, d1_cnt}, 1);
      step();
      check("d1_rise_cleared",
            {30'd0, d1_rise, d1_deb}, 32'b01);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
